// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    // Numeric order is the arbitration order; larger wins.
    typedef enum logic [1:0] {
        PRI_NONE = 2'd0,
        PRI_JMP  = 2'd1,
        PRI_BR   = 2'd2,
        PRI_EXC  = 2'd3
    } pri_t;

    typedef struct packed {
        pri_t        pri;
        logic [31:0] tgt;
    } redirect_t;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam redirect_t   NO_REDIRECT    = '{pri: PRI_NONE, tgt: 32'h0};

endpackage

// File: rtl/pc_incr.sv
// Combinational sequential-address generator; wraps modulo 2^32.
module pc_incr (
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    assign pc_next_o = pc_i + 32'd4;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register, redirect arbitration, instruction-memory request
// handshake and single-entry pending-redirect holding with IF/ID flush.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    output logic [31:0] pc_o,
    input  logic        jump_valid_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    input  logic        exc_valid_i,
    output logic        flush_o,
    output logic        pend_o
);

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next, w_pc_plus4;
    redirect_t   r_pend, w_pend_next;
    redirect_t   w_live, w_commit;
    logic        w_adv;

    pc_incr u_pc_incr (
        .pc_i      (r_pc),
        .pc_next_o (w_pc_plus4)
    );

    assign imem_req_o = (r_state != S_IDLE);
    assign pend_o     = (r_state == S_PENDING);
    assign pc_o       = r_pc;
    assign w_adv      = imem_req_o & imem_ready_i & ~stall_i;

    always_comb begin
        w_live = NO_REDIRECT;
        if (exc_valid_i)
            w_live = '{pri: PRI_EXC, tgt: EXC_VECTOR};
        else if (branch_valid_i)
            w_live = '{pri: PRI_BR, tgt: branch_target_i};
        else if (jump_valid_i)
            w_live = '{pri: PRI_JMP, tgt: jump_target_i};
    end

    // A live redirect of equal priority is newer, so it beats the latched one.
    assign w_commit = (w_live.pri >= r_pend.pri) ? w_live : r_pend;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pend_next  = r_pend;
        flush_o      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_adv) begin
                    if (w_live.pri != PRI_NONE) begin
                        w_pc_next = w_live.tgt;
                        flush_o   = 1'b1;
                    end else begin
                        w_pc_next = w_pc_plus4;
                    end
                end else if (w_live.pri != PRI_NONE) begin
                    w_pend_next  = w_live;
                    w_state_next = S_PENDING;
                end
            end
            S_PENDING: begin
                if (w_adv) begin
                    w_pc_next    = w_commit.tgt;
                    flush_o      = 1'b1;
                    w_pend_next  = NO_REDIRECT;
                    w_state_next = S_FETCH;
                end else if (w_live.pri != PRI_NONE && w_live.pri >= r_pend.pri) begin
                    w_pend_next = w_live;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_pend  <= NO_REDIRECT;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_pend  <= w_pend_next;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench: directed vector table, reset corner cases, and a
// randomized run against a behavioural model of the fetch PC rules.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        imem_ready_i = 1'b0;
    logic        jump_valid_i = 1'b0;
    logic [31:0] jump_target_i = '0;
    logic        branch_valid_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        exc_valid_i = 1'b0;
    logic        imem_req_o, flush_o, pend_o;
    logic [31:0] pc_o;

    int n_cmp = 0;
    int n_err = 0;

    fetch_pc_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .imem_ready_i    (imem_ready_i),
        .imem_req_o      (imem_req_o),
        .pc_o            (pc_o),
        .jump_valid_i    (jump_valid_i),
        .jump_target_i   (jump_target_i),
        .branch_valid_i  (branch_valid_i),
        .branch_target_i (branch_target_i),
        .exc_valid_i     (exc_valid_i),
        .flush_o         (flush_o),
        .pend_o          (pend_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        jv;
        logic [31:0] jt;
        logic        bv;
        logic [31:0] bt;
        logic        exc;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_flush;
        logic        e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic rd, input logic jv, input logic [31:0] jt,
                                input logic bv, input logic [31:0] bt, input logic ex,
                                input logic [31:0] pc, input logic rq, input logic fl, input logic pd);
        vec_t v;
        v.stall = st; v.ready = rd; v.jv = jv; v.jt = jt; v.bv = bv; v.bt = bt; v.exc = ex;
        v.e_pc = pc; v.e_req = rq; v.e_flush = fl; v.e_pend = pd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic st, input logic rd, input logic jv, input logic [31:0] jt,
                         input logic bv, input logic [31:0] bt, input logic ex);
        @(negedge clk);
        stall_i = st; imem_ready_i = rd;
        jump_valid_i = jv; jump_target_i = jt;
        branch_valid_i = bv; branch_target_i = bt;
        exc_valid_i = ex;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pc"},    pc_o, RST_PC);
        check({tag, " req"},   32'(imem_req_o), 32'd0);
        check({tag, " flush"}, 32'(flush_o), 32'd0);
        check({tag, " pend"},  32'(pend_o), 32'd0);
    endtask

    // Behavioural model: pc, whether fetching has started, and a single
    // pending redirect held as (priority, target) with priority 0 = empty.
    logic        m_run;
    logic [31:0] m_pc;
    int          m_pp;
    logic [31:0] m_pt;

    task automatic model_reset();
        m_run = 1'b0; m_pc = RST_PC; m_pp = 0; m_pt = '0;
    endtask

    task automatic random_cycle(input int k);
        logic st, rd, jv, bv, ex, adv, e_flush;
        logic [31:0] jt, bt, lt;
        int lp;
        st = ($urandom_range(0, 4) == 0);
        rd = ($urandom_range(0, 3) != 0);
        jv = ($urandom_range(0, 3) == 0);
        bv = ($urandom_range(0, 4) == 0);
        ex = ($urandom_range(0, 9) == 0);
        jt = $urandom;
        bt = $urandom;
        drive(st, rd, jv, jt, bv, bt, ex);

        lp = ex ? 3 : (bv ? 2 : (jv ? 1 : 0));
        lt = ex ? EXC_PC : (bv ? bt : jt);
        adv = m_run && rd && !st;
        e_flush = adv && (lp != 0 || m_pp != 0);

        check($sformatf("rnd%0d pc", k),    pc_o, m_pc);
        check($sformatf("rnd%0d req", k),   32'(imem_req_o), 32'(m_run));
        check($sformatf("rnd%0d flush", k), 32'(flush_o), 32'(e_flush));
        check($sformatf("rnd%0d pend", k),  32'(pend_o), 32'(m_pp != 0));

        if (!m_run) begin
            m_run = 1'b1;
        end else if (adv) begin
            if (m_pp != 0)
                m_pc = (lp >= m_pp) ? lt : m_pt;
            else if (lp != 0)
                m_pc = lt;
            else
                m_pc = m_pc + 32'd4;
            m_pp = 0;
        end else if (lp != 0 && lp >= m_pp) begin
            m_pp = lp;
            m_pt = lt;
        end
    endtask

    initial begin
        // st rd jv jt bv bt ex | pc req flush pend
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3000,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3000,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3004,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 32'h3008,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 32'h3008,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 32'h3008,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3008,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3008,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3008,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,32'h3400,0, 32'h300C,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h300C,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h300C,1,1,1));
        vecs.push_back(mk(0,1,1,32'h3100,1,32'h3200,1, 32'h3400,1,1,0));
        vecs.push_back(mk(0,1,1,32'h3100,1,32'h3200,0, 32'h4180,1,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3200,1,0,0));
        vecs.push_back(mk(0,0,1,32'h3100,0,0,0, 32'h3204,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,32'h3200,0, 32'h3204,1,0,1));
        vecs.push_back(mk(0,0,1,32'h3300,0,0,0, 32'h3204,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3204,1,1,1));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3200,1,0,0));
        vecs.push_back(mk(0,1,1,32'hFFFF_FFFC,0,0,0, 32'h3204,1,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'hFFFF_FFFC,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h0000_0000,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 32'h0000_0004,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0000_0004,1,0,1));

        #12;
        check_reset_values("por");

        @(posedge clk);
        #2 rst_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].ready, vecs[i].jv, vecs[i].jt,
                  vecs[i].bv, vecs[i].bt, vecs[i].exc);
            check($sformatf("vec%0d pc", i),    pc_o, vecs[i].e_pc);
            check($sformatf("vec%0d req", i),   32'(imem_req_o), 32'(vecs[i].e_req));
            check($sformatf("vec%0d flush", i), 32'(flush_o), 32'(vecs[i].e_flush));
            check($sformatf("vec%0d pend", i),  32'(pend_o), 32'(vecs[i].e_pend));
        end

        // Reset asserted while an exception redirect is pending takes effect
        // without a clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");

        // The pending exception must be gone after reset: sequential fetch resumes.
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("post-rst flush", 32'(flush_o), 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("post-rst pc", pc_o, 32'h3004);

        rst_n = 1'b0;
        #1 check_reset_values("rnd-rst0");
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 600; k++) begin
            random_cycle(k);
            if (k == 300) begin
                #2 rst_n = 1'b0;
                #1 check_reset_values("rnd-rst1");
                @(posedge clk);
                #2 rst_n = 1'b1;
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage program-counter controller for the dynamic pipeline CPU. It owns the PC register and sequences the +4 incrementer. It arbitrates between sequential fetch, ID-stage jumps, EX-stage branch redirects and exception entry. It drives the instruction-memory request handshake and holds any redirect that arrives while fetch cannot advance, then emits a one-cycle flush to IF/ID when that redirect commits.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_4180, exception entry address
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hazard-unit stall; PC must not advance
- imem_ready_i  in  1  instruction memory accepts current request
- imem_req_o  out  1  fetch request valid
- pc_o  out  32  current fetch address (PC register)
- jump_valid_i  in  1  ID-stage jump taken
- jump_target_i  in  32  jump target
- branch_valid_i  in  1  EX-stage branch taken
- branch_target_i  in  32  branch target
- exc_valid_i  in  1  exception raised
- flush_o  out  1  kill IF/ID contents; pulses in the redirect commit cycle
- pend_o  out  1  a redirect is latched and waiting

## Operation
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Redirect priority, highest first: exc (target EXC_VECTOR) > branch > jump > sequential (pc_o+4).
- adv = imem_req_o & imem_ready_i & ~stall_i.
- The sequential address is pc_o + 32'd4, computed modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000. There is no alignment check.
- FSM states:
  - IDLE: imem_req_o=0. Always moves to FETCH on the next edge.
  - FETCH: imem_req_o=1.
    - adv with a live redirect: PC loads the winning target, flush_o=1.
    - adv with no redirect: PC loads pc_o+4.
    - ~adv with a live redirect: the winner is latched into the pending register (priority plus target). Go to PENDING.
    - ~adv with no redirect: hold.
  - PENDING: imem_req_o=1, pend_o=1.
    - A new live redirect replaces the latched one if its priority is greater than or equal to the latched priority. Otherwise it is dropped.
    - On adv: PC loads the higher-priority of live and latched, flush_o=1, pending is cleared. Go to FETCH.
- While imem_req_o=1 and imem_ready_i=0, pc_o is stable.
- stall_i blocks all PC updates, including redirects.
- The pending register holds exactly one entry. It never overflows because lower-priority arrivals are discarded.

## Timing
- Reset values: pc_o=RESET_PC, imem_req_o=0, flush_o=0, pend_o=0, state=IDLE, pending cleared.
- First request: the first rising edge after rst_n deasserts moves to FETCH. imem_req_o=1 with pc_o=RESET_PC from that cycle.
- Redirect latency when it arrives in a cycle with adv=1: flush_o is high in that same cycle (combinational). pc_o equals the target after the next edge.
- Redirect latency when it arrives with adv=0: flush_o is high in the first cycle with adv=1. pc_o equals the target one edge later.
- flush_o is never high for two consecutive cycles unless a new redirect commits in each.
- If rst_n is asserted mid-operation, all state returns to reset values immediately, including any pending redirect.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum (IDLE, FETCH, PENDING)
  - 2-bit redirect priority codes (NONE=0, JMP=1, BR=2, EXC=3)
  - default RESET_PC and EXC_VECTOR constants
- One sub-module: `pc_incr`, a combinational 32-bit +4 adder. All sequential logic lives in fetch_pc_ctrl.

## Test plan
- Reset and sequential fetch: release rst_n, imem_ready_i=1, no stall.
  - pc_o: 3000, 3004, 3008 on successive cycles.
  - imem_req_o rises one cycle after release.
- Stall and not-ready hold: at pc_o=3008, stall_i=1 for 3 cycles, then imem_ready_i=0 for 2 cycles.
  - pc_o stays 3008 for 5 cycles, then goes to 300C.
- Pended redirect: imem_ready_i=0; pulse branch_valid_i with target 3400; ready returns 2 cycles later.
  - pend_o=1 during the wait.
  - flush_o pulses in the first ready cycle.
  - pc_o=3400 after that edge.
- Simultaneous sources: jump (3100), branch (3200) and exc all valid in one adv cycle.
  - pc_o=4180, single flush_o pulse.
  - Repeat without exc: pc_o=3200.
- Pending replacement: while pending holds a jump to 3100, a branch to 3200 arrives, then a later jump to 3300.
  - Commit yields 3200; the later jump is dropped.
- Wrap and mid-operation reset: force pc_o to FFFF_FFFC and advance.
  - pc_o=0000_0000.
  - Assert rst_n low while PENDING: pc_o=3000, pend_o=0, imem_req_o=0 immediately.
